// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit.
//   ifu_state_e  - fetch FSM states
//   ifu_entry_t  - prefetch queue entry {pc, inst}
//   IFU_RESET_PC - default fetch address after reset
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifu_entry_t;

    localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: prefetch queue kept as a shift register so the head is always
// entry 0 and comes straight from a flop. Vacated entries are held at zero,
// so the head reads zero whenever the queue is empty.
// Ports:
//   clk, reset          - clock, async active-high reset
//   push, din           - enqueue din (caller guarantees not full)
//   pop                 - dequeue head (ignored when empty)
//   flush               - drop all entries; overrides push/pop
//   count               - current occupancy
//   head, head_valid    - head entry and occupancy != 0
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  ifu_entry_t       din,
    output logic [CNT_W-1:0] count,
    output ifu_entry_t       head,
    output logic             head_valid
);

    ifu_entry_t       mem_q [DEPTH];
    ifu_entry_t       mem_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] wr_idx;
    logic             head_valid_q;
    logic             pop_ok;

    assign pop_ok = pop && (count_q != '0);

    // Next queue contents: shift on pop, then write the new tail slot.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        wr_idx  = count_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            count_d = '0;
        end else begin
            if (pop_ok) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_d[i] = mem_q[i + 1];
                end
                mem_d[DEPTH - 1] = '0;
                wr_idx = count_q - CNT_W'(1);
            end
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CNT_W'(i) == wr_idx) begin
                        mem_d[i] = din;
                    end
                end
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop_ok);
        end
    end

    // Queue storage and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            count_q      <= '0;
            head_valid_q <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            count_q      <= count_d;
            head_valid_q <= (count_d != '0);
        end
    end

    assign count      = count_q;
    assign head       = mem_q[0];
    assign head_valid = head_valid_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: sequential instruction prefetcher with a DEPTH-entry queue,
// one outstanding memory request at a time, and redirect (branch) restart.
// Optional build macro IFU_PERF_CNT_EN adds the perf_fetch_cnt output.
// Ports:
//   clk, reset                  - clock, async active-high reset
//   imem_req, imem_addr         - memory read request and word byte address
//   imem_ack, imem_rdata        - request completion and read data
//   redirect, redirect_pc       - restart fetch stream at redirect_pc
//   inst_valid/data/pc          - queue head presented to the core
//   inst_ready                  - core pops the head
//   perf_fetch_cnt              - pushed instruction count (IFU_PERF_CNT_EN)
module inst_fetch_unit
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    ifu_state_e       state_q;
    ifu_state_e       state_d;
    logic [31:0]      fetch_pc_q;
    logic [31:0]      fetch_pc_d;
    logic [31:0]      redirect_pc_al;
    logic             imem_req_q;
    logic [31:0]      imem_addr_q;
    logic             push_c;
    logic             pop_c;
    logic [CNT_W-1:0] count;
    logic             head_valid;
    ifu_entry_t       head;
    ifu_entry_t       push_entry;

    assign redirect_pc_al = redirect_pc & 32'hFFFF_FFFC;
    assign pop_c          = head_valid && inst_ready && !redirect;
    assign push_entry     = '{pc: fetch_pc_q, inst: imem_rdata};

    // Next-state, next fetch address and push decision.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc_al;
                    state_d    = REQ;
                end else if (count < CNT_W'(DEPTH)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    // Without an ack the request is still in flight and must be drained.
                    fetch_pc_d = redirect_pc_al;
                    state_d    = imem_ack ? REQ : DRAIN;
                end else if (imem_ack) begin
                    push_c     = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    // Full test ignores a same-cycle pop.
                    state_d    = ((count + CNT_W'(1)) < CNT_W'(DEPTH)) ? REQ : IDLE;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc_al;
                end
                if (imem_ack) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, fetch address and registered memory request outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            imem_req_q  <= (state_d != IDLE);
            // DRAIN keeps presenting the abandoned address until its ack.
            imem_addr_q <= (state_d == DRAIN) ? imem_addr_q : fetch_pc_d;
        end
    end

    ifu_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push_c),
        .pop        (pop_c),
        .flush      (redirect),
        .din        (push_entry),
        .count      (count),
        .head       (head),
        .head_valid (head_valid)
    );

    assign imem_req   = imem_req_q;
    assign imem_addr  = imem_addr_q;
    assign inst_valid = head_valid;
    assign inst_data  = head.inst;
    assign inst_pc    = head.pc;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_q;

    // Pushed-instruction counter; free-running wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= 32'd0;
        end else if (push_c) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed self-checking bench for inst_fetch_unit.
// Instance u_dut uses default parameters; u_wrap uses RESET_PC=32'hFFFFFFF8
// with ack and ready tied high to exercise address wrap.
module tb_inst_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_imem_rdata;
    logic        w_inst_valid;
    logic [31:0] w_inst_data;
    logic [31:0] w_inst_pc;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] w_perf_fetch_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata   = mem_word(imem_addr);
    assign w_imem_rdata = mem_word(w_imem_addr);

    inst_fetch_unit u_dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt)
`endif
    );

    inst_fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'hFFFF_FFF8)
    ) u_wrap (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (w_imem_req),
        .imem_addr   (w_imem_addr),
        .imem_ack    (1'b1),
        .imem_rdata  (w_imem_rdata),
        .redirect    (1'b0),
        .redirect_pc (32'h0),
        .inst_valid  (w_inst_valid),
        .inst_data   (w_inst_data),
        .inst_pc     (w_inst_pc),
        .inst_ready  (1'b1)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt (w_perf_fetch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, then release one time unit after an edge.
    task automatic do_reset(input logic ack, input logic ready);
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ack    = ack;
        inst_ready  = ready;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        imem_ack    = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Reset state.
        tick();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_data", inst_data, 32'h0);
        check("rst_pc", inst_pc, 32'h0);
        check("rst_wrap_addr", w_imem_addr, 32'hFFFF_FFF8);
`ifdef IFU_PERF_CNT_EN
        check("rst_perf", perf_fetch_cnt, 32'd0);
`endif

        // Streaming with zero-wait memory and an always-ready consumer.
        do_reset(1'b1, 1'b1);
        tick();
        check("s_e1_req", 32'(imem_req), 32'd1);
        check("s_e1_addr", imem_addr, 32'h0);
        check("s_e1_valid", 32'(inst_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("s_valid", 32'(inst_valid), 32'd1);
            check("s_pc", inst_pc, 32'(4 * k));
            check("s_data", inst_data, mem_word(32'(4 * k)));
            check("wrap_pc", w_inst_pc, 32'hFFFF_FFF8 + 32'(4 * k));
        end

        // Stalled consumer: exactly four pushes, then fetch resumes at 0x10.
        do_reset(1'b1, 1'b0);
        tick();
        tick();
        tick();
        tick();
        tick();
        check("f_e5_req", 32'(imem_req), 32'd0);
        check("f_e5_pc", inst_pc, 32'h0);
        tick();
        check("f_e6_req", 32'(imem_req), 32'd0);
        check("f_e6_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        tick();
        check("f_e7_req", 32'(imem_req), 32'd0);
        check("f_e7_pc", inst_pc, 32'h4);
        tick();
        check("f_e8_req", 32'(imem_req), 32'd1);
        check("f_e8_addr", imem_addr, 32'h10);
        check("f_e8_pc", inst_pc, 32'h8);
        tick();
        check("f_e9_pc", inst_pc, 32'hC);
        tick();
        check("f_e10_pc", inst_pc, 32'h10);
        check("f_e10_data", inst_data, mem_word(32'h10));

        // Redirect during an unacknowledged request goes through DRAIN.
        do_reset(1'b0, 1'b0);
        tick();
        check("d_e1_req", 32'(imem_req), 32'd1);
        check("d_e1_addr", imem_addr, 32'h0);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        check("d_e2_req", 32'(imem_req), 32'd1);
        check("d_e2_addr", imem_addr, 32'h0);
        check("d_e2_valid", 32'(inst_valid), 32'd0);
        tick();
        check("d_e3_addr", imem_addr, 32'h0);
        imem_ack = 1'b1;
        tick();
        check("d_e4_valid", 32'(inst_valid), 32'd0);
        check("d_e4_req", 32'(imem_req), 32'd1);
        check("d_e4_addr", imem_addr, 32'h40);
        tick();
        check("d_e5_valid", 32'(inst_valid), 32'd1);
        check("d_e5_pc", inst_pc, 32'h40);
        check("d_e5_data", inst_data, mem_word(32'h40));

        // Redirect coincident with ack and pop: flush, aligned restart.
        do_reset(1'b1, 1'b1);
        tick();
        tick();
        tick();
        check("r_e3_pc", inst_pc, 32'h4);
`ifdef IFU_PERF_CNT_EN
        check("r_e3_perf", perf_fetch_cnt, 32'd2);
`endif
        redirect    = 1'b1;
        redirect_pc = 32'h23;
        tick();
        redirect = 1'b0;
        check("r_e4_valid", 32'(inst_valid), 32'd0);
        check("r_e4_pc", inst_pc, 32'h0);
        check("r_e4_data", inst_data, 32'h0);
        check("r_e4_req", 32'(imem_req), 32'd1);
        check("r_e4_addr", imem_addr, 32'h20);
`ifdef IFU_PERF_CNT_EN
        check("r_e4_perf", perf_fetch_cnt, 32'd2);
`endif
        tick();
        check("r_e5_pc", inst_pc, 32'h20);
        check("r_e5_data", inst_data, mem_word(32'h20));

        // Reset during an outstanding request; the late ack must not push.
        do_reset(1'b0, 1'b1);
        tick();
        tick();
        check("a_e2_req", 32'(imem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("a_rst_req", 32'(imem_req), 32'd0);
        check("a_rst_addr", imem_addr, 32'h0);
        check("a_rst_valid", 32'(inst_valid), 32'd0);
        check("a_rst_wrap_addr", w_imem_addr, 32'hFFFF_FFF8);
        imem_ack = 1'b1;
        tick();
        check("a_ack_valid", 32'(inst_valid), 32'd0);
        reset = 1'b0;
        tick();
        check("a_rel_valid", 32'(inst_valid), 32'd0);
        check("a_rel_req", 32'(imem_req), 32'd1);
        tick();
        check("a_push_pc", inst_pc, 32'h0);
        check("a_push_valid", 32'(inst_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the prefetch queue entry count (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0, SHALL be the fetch address loaded on reset.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on posedge.
REQ-004 Port reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 Port imem_req  output  1  SHALL flag a valid instruction-memory read request.
REQ-006 Port imem_addr  output  32  SHALL carry the byte address of the requested word.
REQ-007 Port imem_ack  input  1  SHALL mark imem_rdata valid and complete the request.
REQ-008 Port imem_rdata  input  32  SHALL carry the fetched word, big-endian (byte at addr in [31:24]).
REQ-009 Port redirect  input  1  SHALL request a fetch-stream restart (taken branch/jump).
REQ-010 Port redirect_pc  input  32  SHALL carry the restart address.
REQ-011 Port inst_valid  output  1  SHALL flag a valid instruction at the queue head.
REQ-012 Port inst_data  output  32  SHALL carry the head instruction word.
REQ-013 Port inst_pc  output  32  SHALL carry the head instruction's byte address.
REQ-014 Port inst_ready  input  1  SHALL let the processor pop the head when inst_valid is high.

Function
REQ-015 FSM states IDLE, REQ, DRAIN SHALL be used; imem_req SHALL be high only in REQ or DRAIN.
REQ-016 IDLE->REQ SHALL occur when occupancy < DEPTH and redirect is low.
REQ-017 In REQ, imem_addr SHALL equal fetch_pc and stay stable until imem_ack.
REQ-018 On imem_ack in REQ without redirect, {fetch_pc, imem_rdata} SHALL be pushed, fetch_pc SHALL advance by 4 (mod 2^32, wrapping 32'hFFFFFFFC to 0), and the FSM SHALL stay in REQ if occupancy after push < DEPTH, else go IDLE.
REQ-019 Full test SHALL use current occupancy, ignoring a same-cycle pop; at most one request SHALL be outstanding.
REQ-020 Pop SHALL occur on inst_valid && inst_ready; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-021 inst_valid SHALL be high iff occupancy > 0; inst_data/inst_pc SHALL be 0 when empty.
REQ-022 redirect SHALL take precedence over all else: queue flushed, pop and push suppressed, fetch_pc <= {redirect_pc[31:2],2'b00}.
REQ-023 Redirect in REQ without same-cycle ack SHALL go to DRAIN; DRAIN SHALL hold imem_req and imem_addr until imem_ack, discard that data, then enter REQ.
REQ-024 Redirect with same-cycle ack, or in IDLE, SHALL discard data and go to REQ; redirect in DRAIN SHALL update fetch_pc only.
REQ-025 Zero-wait memory latency: reset release -> REQ at edge 1 -> push at edge 2 -> inst_valid high after edge 2; steady state one word per cycle.

Reset
REQ-026 Reset SHALL force IDLE, fetch_pc=RESET_PC, occupancy 0, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, perf_fetch_cnt=0.
REQ-027 Reset mid-request SHALL abandon the outstanding request without waiting for imem_ack.

Configuration
REQ-028 With macro IFU_PERF_CNT_EN defined, output perf_fetch_cnt (32) SHALL count pushed instructions, wrapping at 2^32, unaffected by redirect.
REQ-029 Without IFU_PERF_CNT_EN, perf_fetch_cnt SHALL not exist and no counter logic SHALL be built.

Structure
REQ-030 Package ifu_pkg SHALL hold the FSM state enum, the queue entry typedef {pc[31:0], inst[31:0]} and the default RESET_PC constant.
REQ-031 Queue SHALL be sub-module ifu_fifo (DEPTH, push, pop, flush, count, head); FSM and fetch_pc stay in inst_fetch_unit.

Verification
REQ-032 Reset, imem_ack tied 1, inst_ready=1 -> inst_pc 0,4,8,... one per cycle from cycle 2; inst_data matches memory.
REQ-033 inst_ready=0, zero-wait memory -> exactly DEPTH (4) pushes, then imem_req=0; raise inst_ready -> fetching resumes at 32'h10.
REQ-034 Memory acks 3 cycles late, redirect to 32'h40 in request cycle 1 -> DRAIN, stale word discarded, next push has inst_pc=32'h40.
REQ-035 redirect_pc=32'h23 coincident with imem_ack and pop -> queue empty next cycle, next request addr 32'h20, perf count unchanged by the dropped word.
REQ-036 RESET_PC=32'hFFFFFFF8, ack tied 1 -> inst_pc FFFFFFF8, FFFFFFFC, 00000000.
REQ-037 Reset asserted while imem_req high, ack pending -> all outputs 0/RESET_PC immediately, no push when the late ack arrives.
